// File: rtl/axi_write_pkg.sv
// Shared FSM state type, B-response codes and width helper for the AXI-Lite write arbiter.
package axi_write_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic int unsigned strb_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/axi_write_arb.sv
// NUM_CH-wide request arbiter producing a one-hot grant and its index.
// AXI_WRITE_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module axi_write_arb
   import axi_write_pkg::*;
#(
   parameter  int unsigned NUM_CH = 2,
   localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_advance,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [IDX_W-1:0]  o_gnt_idx,
   output logic              o_any
);

`ifdef AXI_WRITE_RR_EN
   logic [IDX_W-1:0] r_ptr;

   // Search starts at the pointer and wraps; the first requester found wins.
   always_comb begin : p_search
      int unsigned c;
      o_any     = 1'b0;
      o_gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         c = (int'(r_ptr) + i) % NUM_CH;
         if (!o_any && i_req[c]) begin
            o_any     = 1'b1;
            o_gnt_idx = IDX_W'(c);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= (int'(o_gnt_idx) == NUM_CH - 1) ? '0 : o_gnt_idx + 1'b1;
      end
   end
`else
   logic w_unused;
   assign w_unused = &{1'b0, clk, rst_n, i_advance};

   always_comb begin
      o_any     = 1'b0;
      o_gnt_idx = '0;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (i_req[i-1]) begin
            o_any     = 1'b1;
            o_gnt_idx = IDX_W'(i - 1);
         end
      end
   end
`endif

   always_comb begin
      o_gnt = '0;
      if (o_any) o_gnt[o_gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/axi_lite_write_arb.sv
// AXI-Lite write master arbitrating NUM_CH requesters onto one AW/W/B channel set.
// Define AXI_WRITE_RR_EN for round-robin arbitration; fixed priority otherwise.
module axi_lite_write_arb
   import axi_write_pkg::*;
#(
   parameter  int unsigned NUM_CH = 2,
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned STRB_W = strb_width(DATA_W)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req_i,
   input  logic [NUM_CH*ADDR_W-1:0] addr_i,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
   input  logic [NUM_CH*STRB_W-1:0] strb_i,
   output logic [NUM_CH-1:0]        ack_o,
   output logic [NUM_CH-1:0]        valid_o,
   output logic [NUM_CH-1:0]        err_o,
   output logic                     busy_o,
   output logic [ADDR_W-1:0]        aw_addr_o,
   output logic [2:0]               aw_prot_o,
   output logic                     aw_valid_o,
   input  logic                     aw_ready_i,
   output logic [DATA_W-1:0]        w_data_o,
   output logic [STRB_W-1:0]        w_strb_o,
   output logic                     w_valid_o,
   input  logic                     w_ready_i,
   input  logic [1:0]               b_resp_i,
   input  logic                     b_valid_i,
   output logic                     b_ready_o
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_CH-1:0]   w_gnt;
   logic [IDX_W-1:0]    w_gnt_idx;
   logic                w_any;
   logic                w_take;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_data;
   logic [STRB_W-1:0]   w_sel_strb;

   logic [NUM_CH-1:0]   r_gnt;
   logic [NUM_CH-1:0]   r_ack;
   logic [NUM_CH-1:0]   r_valid;
   logic [NUM_CH-1:0]   r_err;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic [STRB_W-1:0]   r_strb;
   logic                r_aw_valid;
   logic                r_w_valid;

   assign w_take = (r_state == IDLE) && w_any;

   axi_write_arb #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req_i),
      .i_advance (w_take),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_strb = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (w_gnt_idx == IDX_W'(i)) begin
            w_sel_addr = addr_i[i*ADDR_W +: ADDR_W];
            w_sel_data = data_i[i*DATA_W +: DATA_W];
            w_sel_strb = strb_i[i*STRB_W +: STRB_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // AW and W complete independently; a channel already done reads as complete.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_any) w_state_nxt = SEND;
         SEND: if ((!r_aw_valid || aw_ready_i) && (!r_w_valid || w_ready_i))
                  w_state_nxt = RESP;
         RESP: if (b_valid_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt      <= '0;
         r_ack      <= '0;
         r_valid    <= '0;
         r_err      <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_strb     <= '0;
         r_aw_valid <= 1'b0;
         r_w_valid  <= 1'b0;
      end else begin
         r_ack   <= '0;
         r_valid <= '0;
         r_err   <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt      <= w_gnt;
                  r_ack      <= w_gnt;
                  r_addr     <= w_sel_addr;
                  r_data     <= w_sel_data;
                  r_strb     <= w_sel_strb;
                  r_aw_valid <= 1'b1;
                  r_w_valid  <= 1'b1;
               end
            end
            SEND: begin
               if (r_aw_valid && aw_ready_i) r_aw_valid <= 1'b0;
               if (r_w_valid && w_ready_i)   r_w_valid  <= 1'b0;
            end
            RESP: begin
               if (b_valid_i) begin
                  r_valid <= r_gnt;
                  r_err   <= r_gnt & {NUM_CH{b_resp_i != RESP_OKAY}};
               end
            end
            default: ;
         endcase
      end
   end

   assign ack_o      = r_ack;
   assign valid_o    = r_valid;
   assign err_o      = r_err;
   assign busy_o     = (r_state != IDLE);
   assign aw_addr_o  = r_addr;
   assign aw_prot_o  = 3'b000;
   assign aw_valid_o = r_aw_valid;
   assign w_data_o   = r_data;
   assign w_strb_o   = r_strb;
   assign w_valid_o  = r_w_valid;
   assign b_ready_o  = (r_state == RESP);

endmodule

// File: doc/axi_lite_write_arb.md
# axi_lite_write_arb

Parametrised AXI-Lite write master that arbitrates NUM_CH requesters onto one AXI-Lite write channel set. Replaces the two-input fixed maestro/FSM writer: it handles any number of channels, carries full AW/W/B handshakes with independent AW and W completion, and returns per-channel acceptance, completion and error status. Sits between the control blocks (maestro, sequencing FSMs) and the AXI-Lite peripheral interconnect.

## Interface
- NUM_CH, 2, number of requesters; channel 0 is highest priority in fixed mode (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 or 64); STRB_W = DATA_W/8 derived
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  NUM_CH  per-channel write request, level
- addr_i  in  NUM_CH×ADDR_W  per-channel address
- data_i  in  NUM_CH×DATA_W  per-channel write data
- strb_i  in  NUM_CH×STRB_W  per-channel byte strobes
- ack_o  out  NUM_CH  one-cycle pulse: request captured
- valid_o  out  NUM_CH  one-cycle pulse: B response received
- err_o  out  NUM_CH  with valid_o: bresp ≠ OKAY
- busy_o  out  1  FSM not IDLE
- aw_addr_o/aw_valid_o/aw_ready_i  ADDR_W/1/1  AXI-Lite AW (aw_prot fixed 3'b000)
- w_data_o/w_strb_o/w_valid_o/w_ready_i  DATA_W/STRB_W/1/1  AXI-Lite W
- b_resp_i/b_valid_i/b_ready_o  2/1/1  AXI-Lite B

## Operation
- FSM IDLE → SEND → RESP → IDLE; one transaction outstanding.
- IDLE: if any req_i high, arbiter picks channel g; addr/data/strb of g registered, grant index stored, ack_o[g] pulses next cycle, state → SEND. req_i is sampled only in IDLE.
- SEND: aw_valid_o and w_valid_o both high on entry; each drops independently the cycle after its own handshake (valid&ready); payload stable while valid high. When both have completed → RESP. Same-cycle AW and W handshake allowed.
- RESP: b_ready_o = 1; on b_valid_i → valid_o[g] pulse, err_o[g] = (b_resp_i ≠ 2'b00), state → IDLE.
- A requester still holding req_i when FSM returns to IDLE is treated as a new request; requesters drop req_i on seeing ack_o.
- b_valid_i outside RESP is ignored (b_ready_o low).
- Reset values: all valid/ready outputs 0, ack_o/valid_o/err_o 0, busy_o 0, state IDLE, payload registers 0, round-robin pointer 0.
- Reset mid-transaction: aborts immediately, all outputs to reset values; no valid_o is generated for the aborted write.

## Timing
- req_i high in IDLE at cycle N → ack_o and aw_valid_o/w_valid_o high at N+1.
- Zero-wait slave (ready high, b_valid at first opportunity): AW/W handshake at N+1, b_ready_o at N+2, B handshake N+2, valid_o at N+3, IDLE at N+3, next grant taken at N+3 → aw_valid at N+4. Throughput: one write per 3 cycles best case.
- valid_o/err_o are registered, one cycle after B handshake.
- No timeout: SEND/RESP wait indefinitely.

## Configuration
- AXI_WRITE_RR_EN defined: round-robin arbitration; pointer advances to (g+1) mod NUM_CH after each grant; search starts at pointer.
- Undefined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- Package axi_write_pkg: state enum (IDLE, SEND, RESP), RESP_OKAY/RESP_SLVERR constants, helper function for STRB_W.
- Sub-module axi_write_arb: NUM_CH-wide arbiter (one-hot grant + index), fixed or round-robin per AXI_WRITE_RR_EN, advance input pulsed on grant.

## Test plan
- Single write, ch1, addr 0x1000_0040, data 0xDEADBEEF, strb 0xF, zero-wait slave → aw/w at N+1 with those values, ack_o=2'b10 at N+1, valid_o=2'b10 at N+3, err_o=0.
- AW ready 3 cycles before W ready (w_ready delayed 4 cycles) → aw_valid drops after its handshake, w_valid held with stable data, single B accepted, one valid_o pulse.
- ch0 and ch1 request same cycle, fixed mode → ch0 granted first, ch1 granted on return to IDLE; with AXI_WRITE_RR_EN and NUM_CH=4 all requesting continuously → grant order 0,1,2,3,0.
- b_resp_i=2'b10 → valid_o and err_o pulse together on the granted channel only.
- rst_n asserted while in RESP → outputs at reset values same cycle, no valid_o after release; subsequent write completes normally.
- Spurious b_valid_i in IDLE → ignored, b_ready_o stays 0, no valid_o.
